// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V instruction fetch stage:
//   NOP_INSTR        - canonical NOP (addi x0,x0,0) used to fill a killed IF/ID
//   DEFAULT_RESET_PC - default reset program counter
//   fetch_state_e    - fetch FSM state type
//   pc_plus4()       - sequential PC increment, wraps modulo 2^32
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // 32-bit add drops the carry, so 0xFFFF_FFFC + 4 wraps to 0
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/riscv_fetch_perf.sv
// -----------------------------------------------------------------------------
// riscv_fetch_perf
// Free-running performance counters for the fetch stage; both wrap at 2^32.
// Ports:
//   iclk, irst_n        clock, async active-low reset
//   ifetch_inc          an instruction entered IF/ID as valid this cycle
//   iredirect_inc       a redirect request was seen this cycle
//   ocnt_fetch          accepted-fetch count
//   ocnt_redirect       redirect count
// -----------------------------------------------------------------------------
module riscv_fetch_perf (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        ifetch_inc,
  input  logic        iredirect_inc,
  output logic [31:0] ocnt_fetch,
  output logic [31:0] ocnt_redirect
);

  logic [31:0] cnt_fetch_r;
  logic [31:0] cnt_redirect_r;

  // Counter registers
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_fetch_r    <= 32'd0;
      cnt_redirect_r <= 32'd0;
    end else begin
      if (ifetch_inc) begin
        cnt_fetch_r <= cnt_fetch_r + 32'd1;
      end
      if (iredirect_inc) begin
        cnt_redirect_r <= cnt_redirect_r + 32'd1;
      end
    end
  end

  assign ocnt_fetch    = cnt_fetch_r;
  assign ocnt_redirect = cnt_redirect_r;

endmodule

// File: rtl/riscv_fetch.sv
// -----------------------------------------------------------------------------
// riscv_fetch
// RISC-V instruction fetch stage with IF/ID pipeline register, one-entry skid
// buffer for decode stalls and redirect handling across outstanding fetches.
// Optional feature macro: RISCV_FETCH_PERF_EN (adds fetch/redirect counters;
// when undefined the counter ports are tied to zero).
// Ports:
//   iclk, irst_n              clock, async active-low reset
//   istall_d, iflush_d        decode stall / kill IF/ID
//   ipc_src, ipc_target       redirect request and target PC
//   oimem_req, oimem_addr     instruction memory request / address
//   iimem_ack, iimem_rdata    memory response (may arrive in the request cycle)
//   oinstr_d, opc_d,
//   opc_plus4_d, ovalid_d     IF/ID register contents
//   oop_d, ofunct3_d,
//   ofunct7b5_d               decode slices of oinstr_d
//   ocnt_fetch, ocnt_redirect performance counters
// -----------------------------------------------------------------------------
module riscv_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        istall_d,
  input  logic        iflush_d,
  input  logic        ipc_src,
  input  logic [31:0] ipc_target,
  output logic        oimem_req,
  output logic [31:0] oimem_addr,
  input  logic        iimem_ack,
  input  logic [31:0] iimem_rdata,
  output logic [31:0] oinstr_d,
  output logic [31:0] opc_d,
  output logic [31:0] opc_plus4_d,
  output logic        ovalid_d,
  output logic [6:0]  oop_d,
  output logic [2:0]  ofunct3_d,
  output logic        ofunct7b5_d,
  output logic [31:0] ocnt_fetch,
  output logic [31:0] ocnt_redirect
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  tgt_r, tgt_s;
  logic [31:0]  skid_instr_r, skid_pc_r;
  logic         skid_ld_s;
  logic         ifid_ld_s;
  logic [31:0]  ifid_instr_s, ifid_pc_s;
  logic         req_r;
  logic [31:0]  instr_r, pcd_r, pc4d_r;
  logic         valid_r;

  // Next-state, next-PC and IF/ID/skid load decisions
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    tgt_s        = tgt_r;
    skid_ld_s    = 1'b0;
    ifid_ld_s    = 1'b0;
    ifid_instr_s = iimem_rdata;
    ifid_pc_s    = pc_r;
    case (state_r)
      ST_FETCH: begin
        if (iimem_ack) begin
          if (ipc_src) begin
            // fetched word is on the wrong path: drop it
            pc_s = ipc_target;
          end else if (istall_d) begin
            skid_ld_s = 1'b1;
            pc_s      = pc_plus4(pc_r);
            state_s   = ST_HOLD;
          end else begin
            ifid_ld_s = 1'b1;
            pc_s      = pc_plus4(pc_r);
          end
        end else if (ipc_src) begin
          // request still outstanding: keep address stable, remember target
          tgt_s   = ipc_target;
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (ipc_src) begin
          pc_s    = ipc_target;
          state_s = ST_FETCH;
        end else if (!istall_d) begin
          ifid_ld_s    = 1'b1;
          ifid_instr_s = skid_instr_r;
          ifid_pc_s    = skid_pc_r;
          state_s      = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // the newest redirect always wins, even in the cycle the ack lands
        if (ipc_src) begin
          tgt_s = ipc_target;
        end else begin
          tgt_s = tgt_r;
        end
        if (iimem_ack) begin
          pc_s    = tgt_s;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_FETCH;
        pc_s    = pc_r;
      end
    endcase
  end

  // FSM, PC, redirect target, skid buffer and request registers
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      tgt_r        <= 32'd0;
      skid_instr_r <= 32'd0;
      skid_pc_r    <= 32'd0;
      req_r        <= 1'b1;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      tgt_r   <= tgt_s;
      req_r   <= (state_s != ST_HOLD);
      if (skid_ld_s) begin
        skid_instr_r <= iimem_rdata;
        skid_pc_r    <= pc_r;
      end
    end
  end

  // IF/ID register; a flush overrides any load in the same cycle
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      instr_r <= NOP_INSTR;
      pcd_r   <= 32'd0;
      pc4d_r  <= 32'd0;
      valid_r <= 1'b0;
    end else if (iflush_d) begin
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else if (ifid_ld_s) begin
      instr_r <= ifid_instr_s;
      pcd_r   <= ifid_pc_s;
      pc4d_r  <= pc_plus4(ifid_pc_s);
      valid_r <= 1'b1;
    end
  end

  assign oimem_req   = req_r;
  assign oimem_addr  = pc_r;
  assign oinstr_d    = instr_r;
  assign opc_d       = pcd_r;
  assign opc_plus4_d = pc4d_r;
  assign ovalid_d    = valid_r;
  assign oop_d       = instr_r[6:0];
  assign ofunct3_d   = instr_r[14:12];
  assign ofunct7b5_d = instr_r[30];

`ifdef RISCV_FETCH_PERF_EN
  logic fetch_inc_s;
  assign fetch_inc_s = ifid_ld_s & ~iflush_d;

  riscv_fetch_perf u_perf (
    .iclk          (iclk),
    .irst_n        (irst_n),
    .ifetch_inc    (fetch_inc_s),
    .iredirect_inc (ipc_src),
    .ocnt_fetch    (ocnt_fetch),
    .ocnt_redirect (ocnt_redirect)
  );
`else
  assign ocnt_fetch    = 32'd0;
  assign ocnt_redirect = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch
// Self-checking bench for riscv_fetch: directed scenarios followed by random
// traffic compared against a behavioural model of the fetch rules. A second
// instance with RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_riscv_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        iclk;
  logic        irst_n;
  logic        istall_d, iflush_d, ipc_src, iimem_ack;
  logic [31:0] ipc_target, iimem_rdata;
  logic        oimem_req, ovalid_d, ofunct7b5_d;
  logic [31:0] oimem_addr, oinstr_d, opc_d, opc_plus4_d, ocnt_fetch, ocnt_redirect;
  logic [6:0]  oop_d;
  logic [2:0]  ofunct3_d;

  logic        w2_req, w2_valid, w2_f7;
  logic [31:0] w2_addr, w2_instr, w2_pcd, w2_pc4d, w2_cf, w2_cr;
  logic [6:0]  w2_op;
  logic [2:0]  w2_f3;

  int n_pass = 0;
  int n_total = 0;

  riscv_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .iclk(iclk), .irst_n(irst_n), .istall_d(istall_d), .iflush_d(iflush_d),
    .ipc_src(ipc_src), .ipc_target(ipc_target), .oimem_req(oimem_req),
    .oimem_addr(oimem_addr), .iimem_ack(iimem_ack), .iimem_rdata(iimem_rdata),
    .oinstr_d(oinstr_d), .opc_d(opc_d), .opc_plus4_d(opc_plus4_d),
    .ovalid_d(ovalid_d), .oop_d(oop_d), .ofunct3_d(ofunct3_d),
    .ofunct7b5_d(ofunct7b5_d), .ocnt_fetch(ocnt_fetch), .ocnt_redirect(ocnt_redirect)
  );

  riscv_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .iclk(iclk), .irst_n(irst_n), .istall_d(istall_d), .iflush_d(iflush_d),
    .ipc_src(ipc_src), .ipc_target(ipc_target), .oimem_req(w2_req),
    .oimem_addr(w2_addr), .iimem_ack(iimem_ack), .iimem_rdata(iimem_rdata),
    .oinstr_d(w2_instr), .opc_d(w2_pcd), .opc_plus4_d(w2_pc4d),
    .ovalid_d(w2_valid), .oop_d(w2_op), .ofunct3_d(w2_f3),
    .ofunct7b5_d(w2_f7), .ocnt_fetch(w2_cf), .ocnt_redirect(w2_cr)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Memory contents: a scrambled function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5673;
  endfunction

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_sk_instr, m_sk_pc, m_tgt, m_cf, m_cr;
  logic        m_valid, m_hold, m_drain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0;
    m_sk_instr = 32'h0; m_sk_pc = 32'h0; m_tgt = 32'h0;
    m_cf = 32'h0; m_cr = 32'h0;
    m_valid = 1'b0; m_hold = 1'b0; m_drain = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic src,
                            input logic [31:0] tg, input logic ak, input logic [31:0] rd);
    logic        ld;
    logic [31:0] li, lp;
    ld = 1'b0; li = 32'h0; lp = 32'h0;
    if (m_hold) begin
      if (src) begin
        m_hold = 1'b0; m_pc = tg;
      end else if (!st) begin
        ld = 1'b1; li = m_sk_instr; lp = m_sk_pc; m_hold = 1'b0;
      end
    end else if (m_drain) begin
      if (src) m_tgt = tg;
      if (ak) begin
        m_pc = m_tgt; m_drain = 1'b0;
      end
    end else if (ak) begin
      if (src) m_pc = tg;
      else if (st) begin
        m_sk_instr = rd; m_sk_pc = m_pc; m_pc = m_pc + 32'd4; m_hold = 1'b1;
      end else begin
        ld = 1'b1; li = rd; lp = m_pc; m_pc = m_pc + 32'd4;
      end
    end else if (src) begin
      m_drain = 1'b1; m_tgt = tg;
    end
    if (fl) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (ld) begin
      m_instr = li; m_pcd = lp; m_pc4d = lp + 32'd4; m_valid = 1'b1;
      m_cf = m_cf + 32'd1;
    end
    if (src) m_cr = m_cr + 32'd1;
  endtask

  task automatic check_model();
    logic [31:0] ecf, ecr;
`ifdef RISCV_FETCH_PERF_EN
    ecf = m_cf; ecr = m_cr;
`else
    ecf = 32'h0; ecr = 32'h0;
`endif
    chk("addr", oimem_addr, m_pc);
    chk("req", {31'h0, oimem_req}, {31'h0, !m_hold});
    chk("instr", oinstr_d, m_instr);
    chk("pc_d", opc_d, m_pcd);
    chk("pc4_d", opc_plus4_d, m_pc4d);
    chk("valid", {31'h0, ovalid_d}, {31'h0, m_valid});
    chk("op", {25'h0, oop_d}, {25'h0, m_instr[6:0]});
    chk("f3", {29'h0, ofunct3_d}, {29'h0, m_instr[14:12]});
    chk("f7b5", {31'h0, ofunct7b5_d}, {31'h0, m_instr[30]});
    chk("cnt_fetch", ocnt_fetch, ecf);
    chk("cnt_redir", ocnt_redirect, ecr);
  endtask

  task automatic step(input logic st, input logic fl, input logic src,
                      input logic [31:0] tg, input logic ak);
    istall_d = st; iflush_d = fl; ipc_src = src; ipc_target = tg; iimem_ack = ak;
    iimem_rdata = mem_word(oimem_addr);
    model_step(st, fl, src, tg, ak, mem_word(m_pc));
    @(posedge iclk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    istall_d = 1'b0; iflush_d = 1'b0; ipc_src = 1'b0; ipc_target = 32'h0;
    iimem_ack = 1'b0; iimem_rdata = 32'h0;
    irst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_addr", oimem_addr, 32'h0);
    chk("rst_req", {31'h0, oimem_req}, 32'h1);
    chk("rst_valid", {31'h0, ovalid_d}, 32'h0);
    chk("rst_instr", oinstr_d, NOP);
    chk("rst_pc_d", opc_d, 32'h0);
    chk("rst_cnt", ocnt_fetch, 32'h0);
    @(negedge iclk);
    @(negedge iclk);
    irst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r, cf_before;
    irst_n = 1'b1;
    #2;

    // Zero-wait memory: one instruction per cycle
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("zw_addr1", oimem_addr, 32'h4); chk("zw_pcd1", opc_d, 32'h0);
    chk("zw_val1", {31'h0, ovalid_d}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("zw_addr2", oimem_addr, 32'h8); chk("zw_pcd2", opc_d, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("zw_addr3", oimem_addr, 32'hC); chk("zw_pcd3", opc_d, 32'h8);
    chk("zw_instr3", oinstr_d, mem_word(32'h8));

    // Stall on the ack of address 8 for three cycles
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("st_req1", {31'h0, oimem_req}, 32'h0); chk("st_pcd1", opc_d, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("st_req3", {31'h0, oimem_req}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("st_pcd", opc_d, 32'h8); chk("st_addr", oimem_addr, 32'hC);
    chk("st_req", {31'h0, oimem_req}, 32'h1);

    // Redirect during a two-cycle memory wait
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    chk("dr_addr1", oimem_addr, 32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("dr_addr2", oimem_addr, 32'h100); chk("dr_pcd", opc_d, 32'h4);

    // Redirect together with stall while holding a skid entry
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("hr_req0", {31'h0, oimem_req}, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    chk("hr_addr", oimem_addr, 32'h200); chk("hr_req", {31'h0, oimem_req}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("hr_pcd", opc_d, 32'h200);

    // Flush overriding a load
    cf_before = m_cf;
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("fl_instr", oinstr_d, NOP); chk("fl_valid", {31'h0, ovalid_d}, 32'h0);
`ifdef RISCV_FETCH_PERF_EN
    chk("fl_cnt", ocnt_fetch, cf_before);
`else
    chk("fl_cnt", ocnt_fetch, 32'h0);
`endif

    // PC wrap with RESET_PC = 0xFFFF_FFFC
    do_reset();
    chk("wr_addr0", w2_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wr_addr1", w2_addr, 32'h0); chk("wr_pcd", w2_pcd, 32'hFFFF_FFFC);
    chk("wr_pc4", w2_pc4d, 32'h0); chk("wr_valid", {31'h0, w2_valid}, 32'h1);

    // Random traffic with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      logic st, fl, src, ak;
      r = $urandom();
      st  = ($urandom_range(99) < 30);
      fl  = ($urandom_range(99) < 10);
      src = ($urandom_range(99) < 12);
      ak  = ($urandom_range(99) < 60);
      step(st, fl, src, r & 32'hFFFF_FFFC, ak);
      if ((i % 997) == 996) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC loaded at reset.
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
  iclk  input  1  clock
  irst_n  input  1  async active-low reset
  istall_d  input  1  decode stage stalled, hold IF/ID
  iflush_d  input  1  kill IF/ID contents
  ipc_src  input  1  redirect request (branch/jump taken in Execute)
  ipc_target  input  32  redirect target PC
  oimem_req  output  1  instruction fetch request
  oimem_addr  output  32  fetch address
  iimem_ack  input  1  fetch data valid this cycle, may be same cycle as req
  iimem_rdata  input  32  fetched instruction
  oinstr_d  output  32  IF/ID instruction
  opc_d  output  32  IF/ID PC
  opc_plus4_d  output  32  IF/ID PC+4
  ovalid_d  output  1  IF/ID holds a real instruction
  oop_d  output  7  oinstr_d[6:0]
  ofunct3_d  output  3  oinstr_d[14:12]
  ofunct7b5_d  output  1  oinstr_d[30]
  ocnt_fetch  output  32  accepted-fetch counter
  ocnt_redirect  output  32  redirect counter

Function
REQ-003 SHALL implement FSM states FETCH, HOLD, DRAIN.
REQ-004 SHALL drive oimem_req=1 in FETCH and DRAIN, 0 in HOLD.
REQ-005 SHALL hold oimem_addr stable while oimem_req=1 and iimem_ack=0.
REQ-006 In FETCH: ack and !istall_d and !ipc_src: load IF/ID with {rdata, pc, pc+4}, ovalid_d=1, pc<=pc+4, stay FETCH; one instruction per cycle with zero-wait memory.
REQ-007 In FETCH: ack and istall_d and !ipc_src: capture rdata/pc in skid register, pc<=pc+4, go HOLD; IF/ID unchanged.
REQ-008 In HOLD: !istall_d: load IF/ID from skid, ovalid_d=1, go FETCH.
REQ-009 Redirect in FETCH with ack, or in HOLD: discard fetched/skid data, pc<=ipc_target, go FETCH.
REQ-010 Redirect in FETCH without ack: latch ipc_target, go DRAIN.
REQ-011 In DRAIN: a further redirect overwrites the latched target; on ack discard rdata, pc<=latched target, go FETCH.
REQ-012 Redirect SHALL win over istall_d in the same cycle.
REQ-013 iflush_d SHALL set oinstr_d=32'h0000_0013 (NOP), ovalid_d=0, and SHALL override any IF/ID load that cycle; skid contents unaffected.
REQ-014 istall_d without flush SHALL hold all IF/ID outputs.
REQ-015 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-016 oop_d/ofunct3_d/ofunct7b5_d SHALL be combinational slices of oinstr_d.

Reset
REQ-017 On irst_n=0, asynchronously: state=FETCH, pc=RESET_PC, oinstr_d=NOP, opc_d=0, opc_plus4_d=0, ovalid_d=0, skid cleared, latched target=0, counters=0.
REQ-018 Reset mid-request SHALL abandon the outstanding fetch; first request after release uses RESET_PC.

Configuration
REQ-019 Macro RISCV_FETCH_PERF_EN: defined -> ocnt_fetch increments on each IF/ID load with ovalid_d=1, ocnt_redirect on each ipc_src cycle, both wrap at 2^32; undefined -> both ports tie to 0, no counter flops.

Structure
REQ-020 Package riscv_pkg SHALL hold NOP encoding constant, FSM state type, default RESET_PC.
REQ-021 Counters SHALL live in sub-module riscv_fetch_perf, instantiated only under RISCV_FETCH_PERF_EN.

Verification
REQ-022 Zero-wait ack, reset then 4 cycles -> oimem_addr 0,4,8,C; opc_d 0,4,8 with ovalid_d=1.
REQ-023 Ack on addr 8 while istall_d=1 for 3 cycles -> oimem_req=0 during HOLD; opc_d=8 one cycle after stall drops; next addr 0xC.
REQ-024 2-cycle ack latency, ipc_src with target 0x100 in wait cycle -> addr stays 0x8 until ack, rdata discarded, next addr 0x100.
REQ-025 Redirect and istall_d same cycle in HOLD -> skid dropped, next addr = target.
REQ-026 iflush_d with ack -> oinstr_d=0x13, ovalid_d=0; with PERF_EN ocnt_fetch unchanged.
REQ-027 RESET_PC=32'hFFFF_FFFC -> second fetch addr 0, opc_plus4_d=0.
